// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first; result valid WIDTH cycles after accept.
// Backpressure: result is held in DONE until out_ready; no new operand set is accepted until the result is taken.
module subtractor_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din_one,
    input  logic [WIDTH-1:0] din_two,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic             br;
    logic [CW-1:0]    cnt;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic br_nxt;

    // Single full-subtractor cell fed from the LSB of each operand shift register.
    always_comb begin
        a_bit  = a_sh[0];
        b_bit  = b_sh[0];
        d_bit  = a_bit ^ b_bit ^ br;
        br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= din_one;
                        b_sh  <= din_two;
                        br    <= bin;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // Result bits enter at the MSB and walk down; after WIDTH shifts bit 0 sits at the LSB.
                    diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                    br     <= br_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_q;
    assign bout      = br;

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed and randomised checks of subtractor_serial at WIDTH = 8.
module tb_subtractor_serial;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din_one;
    logic [WIDTH-1:0] din_two;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int n_chk = 0;
    int n_err = 0;

    subtractor_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_one   (din_one),
        .din_two   (din_two),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge with in_ready high; returns at #1 after the edge where out_valid is seen.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] exp_d, input logic exp_bo);
        int cyc;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        din_one  = a;
        din_two  = b;
        bin      = bi;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din_one  = ~a;
        din_two  = 8'($urandom);
        bin      = ~bi;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd8);
        chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
        chk({tag, "_bout"}, 32'(bout), 32'(exp_bo));
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_ret_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_ret_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    logic [8:0] exp_q[$];
    logic [8:0] full;
    logic [8:0] head;
    int         acc;
    int         got;
    int         cycles;
    logic       seen;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din_one   = '0;
        din_two   = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);

        run_op("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        finish_op("basic");
        run_op("under", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        finish_op("under");
        run_op("binonly", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        finish_op("binonly");
        run_op("edge80", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        finish_op("edge80");
        run_op("ffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        finish_op("ffff");

        // Hold the result while new operand sets are offered.
        out_ready = 1'b0;
        run_op("bp", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            din_one  = 8'($urandom);
            din_two  = 8'($urandom);
            bin      = 1'($urandom);
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_diff", 32'(diff), 32'h4B);
            chk("bp_bout", 32'(bout), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        finish_op("bp");
        run_op("after_bp", 8'h3C, 8'hC3, 1'b1, 8'h78, 1'b1);
        finish_op("after_bp");

        // Reset in the 4th CALC cycle discards the operation.
        in_valid = 1'b1;
        din_one  = 8'hF0;
        din_two  = 8'h0F;
        bin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_bout", 32'(bout), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        run_op("post_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        finish_op("post_rst");

        // Random operand sets with random handshake gaps against a 9-bit reference subtract.
        acc    = 0;
        got    = 0;
        cycles = 0;
        while ((acc < 1000 || exp_q.size() != 0) && cycles < 60000) begin
            in_valid  = (acc < 1000) && ($urandom_range(0, 3) == 0);
            din_one   = 8'($urandom);
            din_two   = 8'($urandom);
            bin       = 1'($urandom);
            out_ready = 1'($urandom);
            if (in_valid && in_ready) begin
                full = {1'b0, din_one} - {1'b0, din_two} - {8'd0, bin};
                exp_q.push_back(full);
                acc++;
            end
            if (out_valid && out_ready) begin
                got++;
                if (exp_q.size() == 0) begin
                    chk("rand_extra_result", 32'(got), 32'(acc));
                end else begin
                    head = exp_q.pop_front();
                    chk("rand_result", 32'({bout, diff}), 32'(head));
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        chk("rand_accepted", 32'(acc), 32'd1000);
        chk("rand_results", 32'(got), 32'd1000);
        chk("rand_pending", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
